// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM master that sequences interval-timer register
// accesses (period/control writes, snapshot reads) from a command port and
// services timeout events by clearing the timer status register.
// Optional build macro: TIMER_CTRL_STATUS_POLL_EN. When it is defined, the
// status register is also polled while idle, so timeouts are serviced even
// when the timer interrupt is disabled.
module timer_ctrl_master #(
    parameter int PERIOD_W   = 64,
    parameter int TICK_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [PERIOD_W-1:0]   cmd_period,
    input  logic                  cmd_continuous,
    input  logic                  cmd_irq_en,
    output logic                  rsp_valid,
    output logic [PERIOD_W-1:0]   snap_value,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [3:0]            m_address,
    output logic                  m_chipselect,
    output logic                  m_write_n,
    output logic [15:0]           m_writedata,
    input  logic [15:0]           m_readdata,
    input  logic                  m_irq
);

    localparam int NHW = PERIOD_W / 16;
    localparam logic [1:0] IDX_LAST = 2'(NHW - 1);

    if (PERIOD_W != 32 && PERIOD_W != 64) begin : g_bad_period
        $fatal(1, "timer_ctrl_master: PERIOD_W must be 32 or 64");
    end

    typedef enum logic [1:0] {
        OP_CONFIG   = 2'b00,
        OP_START    = 2'b01,
        OP_STOP     = 2'b10,
        OP_SNAPSHOT = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        WR_PER,
        WR_CTL,
        SNAP_WR,
        SNAP_RD,
        SNAP_LAST,
        RSP,
        TO_CLR,
        TO_WAIT
    } state_e;

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [PERIOD_W-1:0]   period_q;
    logic                  cont_q;
    logic                  ien_q;
    logic [1:0]            idx_q;
    logic [PERIOD_W-1:0]   snap_buf_q;
    logic [PERIOD_W-1:0]   snap_q;
    logic [TICK_CNT_W-1:0] tick_cnt_q;
    logic                  timeout_req;
    logic                  accept;

`ifdef TIMER_CTRL_STATUS_POLL_EN
    logic flag_q;

    // Remember whether the previous cycle addressed the status register.
    always_ff @(posedge clk) begin
        if (reset) flag_q <= 1'b0;
        else       flag_q <= (m_address == 4'd0);
    end

    always_comb timeout_req = m_irq | (flag_q & m_readdata[0]);
`else
    always_comb timeout_req = m_irq;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and bus/handshake outputs.
    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        accept       = 1'b0;
        rsp_valid    = 1'b0;
        tick         = 1'b0;
        m_address    = '0;
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = ~reset & ~timeout_req;
                accept    = cmd_valid & cmd_ready;
                if (timeout_req) begin
                    state_d = TO_CLR;
                end else if (accept) begin
                    unique case (op_e'(cmd_op))
                        OP_CONFIG:   state_d = WR_PER;
                        OP_SNAPSHOT: state_d = SNAP_WR;
                        default:     state_d = WR_CTL;
                    endcase
                end
            end
            WR_PER: begin
                m_address    = 4'd2 + {2'b00, idx_q};
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = period_q[15:0];
                if (idx_q == IDX_LAST) state_d = WR_CTL;
            end
            WR_CTL: begin
                m_address    = 4'd1;
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_writedata  = {12'd0, op_q == OP_STOP, op_q == OP_START, cont_q, ien_q};
                state_d      = RSP;
            end
            SNAP_WR: begin
                m_address    = 4'd6;
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                state_d      = SNAP_RD;
            end
            SNAP_RD: begin
                m_address = 4'd6 + {2'b00, idx_q};
                if (idx_q == IDX_LAST) state_d = SNAP_LAST;
            end
            SNAP_LAST: state_d = RSP;
            RSP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            TO_CLR: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                tick         = 1'b1;
                state_d      = TO_WAIT;
            end
            TO_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latches, halfword index, snapshot assembly and timeout counter.
    // Period halfwords shift out LS first; snapshot halfwords shift in from the
    // top so the final read completes the value in the same edge it is published.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_CONFIG;
            period_q   <= '0;
            cont_q     <= 1'b0;
            ien_q      <= 1'b0;
            idx_q      <= '0;
            snap_buf_q <= '0;
            snap_q     <= '0;
            tick_cnt_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op_e'(cmd_op);
                if (op_e'(cmd_op) == OP_CONFIG) begin
                    period_q <= cmd_period;
                    cont_q   <= cmd_continuous;
                    ien_q    <= cmd_irq_en;
                end
            end
            if ((state_q == WR_PER || state_q == SNAP_RD) && idx_q != IDX_LAST)
                idx_q <= idx_q + 2'd1;
            else
                idx_q <= '0;
            if (state_q == WR_PER)
                period_q <= period_q >> 16;
            if (state_q == SNAP_RD && idx_q != 2'd0)
                snap_buf_q <= {m_readdata, snap_buf_q[PERIOD_W-1:16]};
            if (state_q == SNAP_LAST)
                snap_q <= {m_readdata, snap_buf_q[PERIOD_W-1:16]};
            if (state_q == TO_CLR)
                tick_cnt_q <= tick_cnt_q + TICK_CNT_W'(1);
        end
    end

    assign snap_value = snap_q;
    assign tick_count = tick_cnt_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Testbench for timer_ctrl_master: a small timer slave model drives
// m_readdata/m_irq, a behavioural expectation queue is checked every cycle,
// and directed scenarios pin the model with literal expectations.
module tb_timer_ctrl_master;

    localparam int PW  = 64;
    localparam int TCW = 4;
    localparam int NHW = PW / 16;
    localparam logic [63:0] SNAP_CNT = 64'h0123_4567_89AB_CDEF;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'b00;
    logic [PW-1:0]  cmd_period = '0;
    logic           cmd_continuous = 1'b0;
    logic           cmd_irq_en = 1'b0;
    logic           rsp_valid;
    logic [PW-1:0]  snap_value;
    logic           tick;
    logic [TCW-1:0] tick_count;
    logic [3:0]     m_address;
    logic           m_chipselect;
    logic           m_write_n;
    logic [15:0]    m_writedata;
    logic [15:0]    m_readdata;
    logic           m_irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_ctrl_master #(.PERIOD_W(PW), .TICK_CNT_W(TCW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
        .rsp_valid(rsp_valid), .snap_value(snap_value), .tick(tick), .tick_count(tick_count),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_irq(m_irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timer slave model ----------------
    logic        s_to = 1'b0;
    logic [15:0] s_ctrl = 16'h0;
    logic [63:0] s_snap = 64'h0;
    logic        s_fire = 1'b0;
    logic [15:0] rd_q = 16'h0;
    logic        irq_q = 1'b0;
    logic [19:0] wlog[$];

    assign m_readdata = rd_q;
    assign m_irq      = irq_q;

    function automatic logic [15:0] s_read(input logic [3:0] a);
        case (a)
            4'd0:    return {15'd0, s_to};
            4'd1:    return s_ctrl;
            4'd6:    return s_snap[15:0];
            4'd7:    return s_snap[31:16];
            4'd8:    return s_snap[47:32];
            4'd9:    return s_snap[63:48];
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_q  <= s_read(m_address);
        irq_q <= s_to & s_ctrl[0];
        if (!reset && m_chipselect && !m_write_n) begin
            wlog.push_back({m_address, m_writedata});
            case (m_address)
                4'd0:    s_to <= 1'b0;
                4'd1:    s_ctrl <= m_writedata;
                4'd6:    s_snap <= SNAP_CNT;
                default: ;
            endcase
        end
        if (s_fire) s_to <= 1'b1;
    end

    // ---------------- behavioural expectation model ----------------
    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic        rsp;
        logic        tk;
        logic        snap_upd;
    } exp_t;

    exp_t           q[$];
    logic           m_cont = 1'b0;
    logic           m_ien = 1'b0;
    logic           m_flag = 1'b0;
    logic [TCW-1:0] m_tc = '0;
    logic [PW-1:0]  m_snap = '0;

    function automatic exp_t mk(input logic wr, input logic [3:0] a, input logic [15:0] d,
                                input logic rsp, input logic tk, input logic su);
        exp_t e;
        e.wr = wr; e.addr = a; e.wd = d; e.rsp = rsp; e.tk = tk; e.snap_upd = su;
        return e;
    endfunction

    always @(negedge clk) begin : model
        exp_t e;
        logic idle;
        logic treq;
        if (reset) begin
            chk("cmd_ready_rst", {63'd0, cmd_ready}, 64'd0);
            q.delete();
            m_cont = 1'b0; m_ien = 1'b0; m_flag = 1'b0; m_tc = '0; m_snap = '0;
        end else begin
            idle = (q.size() == 0);
            e    = idle ? mk(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0) : q[0];
            treq = m_irq;
`ifdef TIMER_CTRL_STATUS_POLL_EN
            treq = treq | (m_flag & m_readdata[0]);
`endif
            if (e.snap_upd) m_snap = SNAP_CNT;
            chk("cmd_ready",    {63'd0, cmd_ready},    {63'd0, idle & ~treq});
            chk("m_address",    {60'd0, m_address},    {60'd0, e.addr});
            chk("m_chipselect", {63'd0, m_chipselect}, {63'd0, e.wr});
            chk("m_write_n",    {63'd0, m_write_n},    {63'd0, ~e.wr});
            chk("m_writedata",  {48'd0, m_writedata},  {48'd0, e.wd});
            chk("rsp_valid",    {63'd0, rsp_valid},    {63'd0, e.rsp});
            chk("tick",         {63'd0, tick},         {63'd0, e.tk});
            chk("tick_count",   64'(tick_count),       64'(m_tc));
            chk("snap_value",   snap_value,            m_snap);
            if (e.tk) m_tc = m_tc + 1'b1;
            m_flag = (e.addr == 4'd0);
            if (!idle) begin
                void'(q.pop_front());
            end else if (treq) begin
                q.push_back(mk(1'b1, 4'd0, 16'h0, 1'b0, 1'b1, 1'b0));
                q.push_back(mk(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0));
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'b00: begin
                        m_cont = cmd_continuous;
                        m_ien  = cmd_irq_en;
                        for (int k = 0; k < NHW; k++)
                            q.push_back(mk(1'b1, 4'(2 + k), cmd_period[16*k +: 16], 1'b0, 1'b0, 1'b0));
                        q.push_back(mk(1'b1, 4'd1, {14'd0, m_cont, m_ien}, 1'b0, 1'b0, 1'b0));
                    end
                    2'b01: q.push_back(mk(1'b1, 4'd1, {12'd0, 2'b01, m_cont, m_ien}, 1'b0, 1'b0, 1'b0));
                    2'b10: q.push_back(mk(1'b1, 4'd1, {12'd0, 2'b10, m_cont, m_ien}, 1'b0, 1'b0, 1'b0));
                    default: begin
                        q.push_back(mk(1'b1, 4'd6, 16'h0, 1'b0, 1'b0, 1'b0));
                        for (int k = 0; k < NHW; k++)
                            q.push_back(mk(1'b0, 4'(6 + k), 16'h0, 1'b0, 1'b0, 1'b0));
                        q.push_back(mk(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0));
                    end
                endcase
                q.push_back(mk(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, (cmd_op == 2'b11)));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fire();
        s_fire = 1'b1;
        @(posedge clk);
        #1 s_fire = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [63:0] per, input logic c,
                          input logic ie, output int aw, output int lat);
        cmd_op = op; cmd_period = per; cmd_continuous = c; cmd_irq_en = ie;
        cmd_valid = 1'b1;
        aw = 0; lat = 0;
        @(negedge clk);
        while (!cmd_ready && aw < 40) begin
            @(posedge clk); #1; aw++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_bound: got no cmd_ready expected accept within 40 cycles");
            @(posedge clk); #1 cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
            @(negedge clk);
        end
        if (!rsp_valid) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_bound: got no rsp_valid expected within 40 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int aw;
        int lat;
        int n0;
        int w;

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp",   {63'd0, rsp_valid},    64'd0);
        chk("rst_tick",  {63'd0, tick},         64'd0);
        chk("rst_tc",    64'(tick_count),       64'd0);
        chk("rst_snap",  snap_value,            64'd0);
        chk("rst_cs",    {63'd0, m_chipselect}, 64'd0);
        chk("rst_wn",    {63'd0, m_write_n},    64'd1);
        chk("rst_addr",  {60'd0, m_address},    64'd0);
        chk("rst_ready", {63'd0, cmd_ready},    64'd1);
        @(posedge clk); #1;

        // CONFIG
        wlog.delete();
        do_cmd(2'b00, 64'h0000_0000_05F5_E0FF, 1'b1, 1'b1, aw, lat);
        chk("cfg_lat", 64'(lat), 64'd6);
        chk("cfg_nwr", 64'(wlog.size()), 64'd5);
        if (wlog.size() == 5) begin
            chk("cfg_w0", 64'(wlog[0]), 64'h2E0FF);
            chk("cfg_w1", 64'(wlog[1]), 64'h305F5);
            chk("cfg_w2", 64'(wlog[2]), 64'h40000);
            chk("cfg_w3", 64'(wlog[3]), 64'h50000);
            chk("cfg_w4", 64'(wlog[4]), 64'h10003);
        end

        // START then STOP
        wlog.delete();
        do_cmd(2'b01, 64'h0, 1'b0, 1'b0, aw, lat);
        chk("start_lat", 64'(lat), 64'd2);
        chk("start_nwr", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("start_w", 64'(wlog[0]), 64'h10007);
        wlog.delete();
        do_cmd(2'b10, 64'h0, 1'b0, 1'b0, aw, lat);
        chk("stop_lat", 64'(lat), 64'd2);
        chk("stop_nwr", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("stop_w", 64'(wlog[0]), 64'h1000B);

        // SNAPSHOT
        wlog.delete();
        do_cmd(2'b11, 64'h0, 1'b0, 1'b0, aw, lat);
        chk("snap_lat", 64'(lat), 64'd7);
        chk("snap_nwr", 64'(wlog.size()), 64'd1);
        if (wlog.size() == 1) chk("snap_w", 64'(wlog[0]), 64'h60000);
        chk("snap_val", snap_value, 64'h0123_4567_89AB_CDEF);

        // Timeout rises together with a pending command
        wlog.delete();
        fire();
        @(posedge clk); #1;
        do_cmd(2'b01, 64'h0, 1'b0, 1'b0, aw, lat);
        chk("irq_acc_wait", 64'(aw), 64'd3);
        chk("irq_tc", 64'(tick_count), 64'd1);
        chk("irq_nwr", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("irq_w0", 64'(wlog[0]), 64'h00000);
            chk("irq_w1", 64'(wlog[1]), 64'h10007);
        end

        // Reset in the middle of SNAP_RD
        cmd_op = 2'b11; cmd_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 40) begin
            @(posedge clk); #1; w++;
            @(negedge clk);
        end
        chk("midrst_accept", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_addr7", {60'd0, m_address}, 64'd7);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_addr", {60'd0, m_address},    64'd0);
        chk("midrst_cs",   {63'd0, m_chipselect}, 64'd0);
        chk("midrst_wn",   {63'd0, m_write_n},    64'd1);
        chk("midrst_snap", snap_value,            64'd0);
        chk("midrst_tc",   64'(tick_count),       64'd0);
        @(posedge clk); #1;

        // Counter wrap after 2^TCW services
        for (int i = 0; i < (1 << TCW); i++) begin
            fire();
            repeat (6) @(posedge clk);
            #1;
            if (i == (1 << TCW) - 2) chk("wrap_pre", 64'(tick_count), 64'd15);
        end
        chk("wrap_0", 64'(tick_count), 64'd0);

        // Status set with the interrupt disabled
        do_cmd(2'b00, 64'h0000_0000_0000_1000, 1'b0, 1'b0, aw, lat);
        wlog.delete();
        fire();
        repeat (8) @(posedge clk);
        #1;
        n0 = 0;
        foreach (wlog[i]) if (wlog[i][19:16] == 4'd0) n0++;
`ifdef TIMER_CTRL_STATUS_POLL_EN
        chk("poll_nclr", 64'(n0), 64'd1);
        chk("poll_tc",   64'(tick_count), 64'd1);
`else
        chk("nopoll_nclr", 64'(n0), 64'd0);
        chk("nopoll_tc",   64'(tick_count), 64'd0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
